cut_bist_controller: RTL and testbench
======================================

# cut_bist_controller

Built-in self-test controller that drives the stimulus side of a 9-input / 2-output combinational circuit-under-test (CUT) and compacts its responses. It produces pseudo-random input vectors from an LFSR and applies each one for a programmable settle time. It captures the CUT outputs into a MISR and, after N patterns, compares the signature against a golden value. It sits opposite the CUT netlists used by the parallel fault simulator and provides the hardware counterpart of the simulator's pattern-apply/response-check loop.

## Interface
- N_PATTERNS, 256: patterns per run; legal 1..511.
- SETTLE_CYCLES, 1: cycles each vector is held before capture; legal 0..15.
- LFSR_SEED, 9'h001: LFSR load value; 0 is replaced by 9'h001.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; sampled only in IDLE.
- abort  input  1  cancels a run in progress; returns to IDLE next edge.
- golden_sig  input  16  expected MISR value; sampled in COMPARE.
- cut_in  output  9  registered CUT stimulus, bit order {a[3:0], b, c, d[2:0]} MSB→LSB.
- cut_out  input  2  CUT response {f[1], f[0]}.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse when the verdict is valid.
- pass  output  1  signature == golden_sig; held until next start.
- signature  output  16  current MISR contents.
- pat_count  output  9  patterns captured in the current run.

## Operation
- Reset values: state IDLE, cut_in=9'h000, busy=0, done=0, pass=0, signature=16'h0000, pat_count=0, settle counter=0.
- Register updates by state:
  - IDLE: on start, load lfsr←LFSR_SEED (0→1), misr←0, pat_count←0, settle←0, pass←0; go to APPLY.
  - APPLY: cut_in=lfsr. If settle==SETTLE_CYCLES, go to CAPTURE; else settle+1.
  - CAPTURE:
    - misr←misr_next(cut_out), lfsr←lfsr_next, pat_count+1, settle←0.
    - If pat_count==N_PATTERNS-1 (pre-increment), go to COMPARE; else APPLY.
  - COMPARE: pass←(misr==golden_sig); go to DONE.
  - DONE: done=1 for this single cycle; go to IDLE.
- LFSR: 9-bit Fibonacci, x^9+x^5+1, with lfsr_next={lfsr[7:0], lfsr[8]^lfsr[4]}. Period 511.
- MISR: 16-bit, polynomial 16'h1021. misr_next = {misr[14:0],1'b0} ^ (misr[15] ? 16'h1021 : 0) ^ {14'b0, cut_out}.
- abort (any non-IDLE state): next edge goes to IDLE with busy=0, no done pulse, pass=0. signature and pat_count hold their last values.
- start while not in IDLE is ignored. start and abort together in IDLE: start wins. abort has priority over every other transition.
- Reset asserted mid-run restores all reset values immediately.
- cut_in holds the last applied vector after the run ends.

## Timing
- cut_in changes only on the edge entering APPLY. It is stable for SETTLE_CYCLES+1 cycles before the CAPTURE edge samples cut_out.
- Per pattern: SETTLE_CYCLES+2 cycles (APPLY dwell + CAPTURE).
- Run length: start sampled at edge 0; done is high N_PATTERNS*(SETTLE_CYCLES+2)+2 cycles later (COMPARE, then DONE).
- busy falls on the same edge that done falls. A new start is accepted on the first IDLE cycle after DONE.
- No combinational path from cut_out to any output. All outputs are registered or decoded from state only.

## Structure
- Package cut_bist_pkg holds:
  - state enum {IDLE, APPLY, CAPTURE, COMPARE, DONE};
  - LFSR_W=9 and LFSR_TAPS=9'h110;
  - MISR_W=16 and MISR_POLY=16'h1021;
  - function misr_step.
- One sub-module: cut_bist_misr (MISR register with clear and enable), reused by the fault-simulator hardware models.
- LFSR, counters and FSM live in the top module.

## Test plan
- Reset release, idle 10 cycles: all outputs at reset values, cut_in=9'h000, no done.
- N_PATTERNS=2, SETTLE_CYCLES=0, seed 1, cut_out tied 2'b01, golden_sig=16'h0003:
  - cut_in shows 9'h001, then 9'h002;
  - signature ends 16'h0003; done pulses 6 cycles after start with pass=1.
- Same run with golden_sig=16'h0004: done pulses with pass=0, signature=16'h0003.
- N_PATTERNS=511, cut_out driven by a golden CUT model: signature matches the software reference. Repeating the run with a single stuck-at fault injected in the model gives pass=0.
- Abort asserted during the 3rd APPLY: IDLE next cycle, busy=0, no done, pat_count=2. A following start restarts from seed 1 and pat_count=0.
- Async rst pulse mid-CAPTURE, not aligned to clk: outputs reset immediately. A second start during busy is ignored (pat_count sequence unbroken).

Source files
------------

// File: rtl/cut_bist_pkg.sv
// cut_bist_pkg
// Shared types, constants and step functions for the CUT BIST controller
// and the MISR block.
//   state_t    : controller FSM states
//   LFSR_W     : stimulus LFSR width (9)
//   LFSR_TAPS  : Fibonacci taps for x^9 + x^5 + 1 (bits 8 and 4)
//   MISR_W     : signature register width (16)
//   MISR_POLY  : MISR feedback polynomial
//   misr_step  : one MISR clock of compaction for a 2-bit response
//   lfsr_step  : one LFSR advance
package cut_bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        APPLY   = 3'd1,
        CAPTURE = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int                LFSR_W    = 9;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 9'h110;

    localparam int                MISR_W    = 16;
    localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

    // Shift left, fold the outgoing MSB back through the polynomial,
    // then XOR the response into the two LSBs.
    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] cur,
                                                     input logic [1:0]        resp);
        logic [MISR_W-1:0] shifted;
        shifted = {cur[MISR_W-2:0], 1'b0};
        if (cur[MISR_W-1]) begin
            shifted = shifted ^ MISR_POLY;
        end
        return shifted ^ {{(MISR_W-2){1'b0}}, resp};
    endfunction

    // Feedback bit is the parity of the tapped bits, shifted in at the LSB.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/cut_bist_misr.sv
// cut_bist_misr
// Multiple-input signature register compacting a 2-bit CUT response.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset (signature -> 0)
//   clr   in   synchronous clear, wins over en
//   en    in   compact resp into the signature this edge
//   resp  in   2-bit response {f[1], f[0]}
//   sig   out  current signature
module cut_bist_misr
    import cut_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [1:0]        resp,
    output logic [MISR_W-1:0] sig
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= misr_step(sig, resp);
        end
    end

endmodule

// File: rtl/cut_bist_controller.sv
// cut_bist_controller
// BIST controller for a 9-input / 2-output combinational CUT. Applies
// LFSR vectors, holds each for SETTLE_CYCLES+1 cycles, compacts the CUT
// response into a MISR and compares the final signature to golden_sig.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   begin a run (sampled only in IDLE)
//   abort       in   cancel a run in progress
//   golden_sig  in   expected signature, sampled in COMPARE
//   cut_in      out  registered CUT stimulus {a[3:0], b, c, d[2:0]}
//   cut_out     in   CUT response {f[1], f[0]}
//   busy        out  run in progress (any state but IDLE)
//   done        out  one-cycle verdict-valid pulse
//   pass        out  last verdict, held until the next start
//   signature   out  current MISR contents
//   pat_count   out  patterns captured in the current run
//   state_dbg   out  FSM state for observation
//
// Handshake: start and abort are single-cycle level requests sampled on
// the rising edge. start is honoured only in IDLE (and beats abort there);
// abort in any other state returns to IDLE on the next edge without a done
// pulse and clears pass. There is no back-pressure.
module cut_bist_controller
    import cut_bist_pkg::*;
#(
    parameter int          N_PATTERNS    = 256,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [8:0]  LFSR_SEED     = 9'h001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] golden_sig,
    output logic [8:0]  cut_in,
    input  logic [1:0]  cut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [8:0]  pat_count,
    output logic [2:0]  state_dbg
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [8:0] SEED_EFF    = (LFSR_SEED == 9'h000) ? 9'h001 : LFSR_SEED;
    localparam logic [8:0] LAST_PAT    = 9'(N_PATTERNS - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  lfsr;
    logic [3:0]  settle;
    logic        start_run;
    logic        capture_en;
    logic        last_pat;

    assign last_pat = (pat_count == LAST_PAT);

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM next state / strobes ----------------
    always_comb begin
        state_nxt  = state;
        start_run  = 1'b0;
        capture_en = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = APPLY;
                    start_run = 1'b1;
                end
            end
            APPLY: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (settle == SETTLE_LAST) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    capture_en = 1'b1;
                    state_nxt  = last_pat ? COMPARE : APPLY;
                end
            end
            COMPARE: begin
                state_nxt = abort ? IDLE : DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State-decoded outputs: nothing here depends on cut_out.
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr      <= '0;
            cut_in    <= '0;
            pat_count <= '0;
            settle    <= '0;
            pass      <= 1'b0;
        end else if (start_run) begin
            lfsr      <= SEED_EFF;
            cut_in    <= SEED_EFF;
            pat_count <= '0;
            settle    <= '0;
            pass      <= 1'b0;
        end else if (abort && (state != IDLE)) begin
            // cut_in, pat_count and lfsr keep their last values.
            settle <= '0;
            pass   <= 1'b0;
        end else begin
            case (state)
                APPLY: begin
                    if (settle != SETTLE_LAST) begin
                        settle <= settle + 4'd1;
                    end
                end
                CAPTURE: begin
                    lfsr      <= lfsr_step(lfsr);
                    pat_count <= pat_count + 9'd1;
                    settle    <= '0;
                    // cut_in only moves when re-entering APPLY, so after the
                    // final pattern it keeps showing the last applied vector.
                    if (!last_pat) begin
                        cut_in <= lfsr_step(lfsr);
                    end
                end
                COMPARE: begin
                    pass <= (signature == golden_sig);
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- Signature register ----------------
    cut_bist_misr u_misr (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_run),
        .en   (capture_en),
        .resp (cut_out),
        .sig  (signature)
    );

endmodule

// File: tb/tb_cut_bist_controller.sv
// Testbench for cut_bist_controller. Two instances: a short run (2 patterns,
// no settle) and a full-period run (511 patterns, settle 1, zero seed) whose
// CUT is a behavioural model with optional stuck-at faults.
module tb_cut_bist_controller;

  localparam int NA = 2;
  localparam int SA = 0;
  localparam int PA = SA + 2;
  localparam int NB = 511;
  localparam int SB = 1;
  localparam int PB = SB + 2;

  logic        clk;
  logic        rst;

  logic        start_a, abort_a;
  logic [15:0] golden_a;
  logic [1:0]  cut_out_a;
  logic [8:0]  cut_in_a, pat_count_a;
  logic        busy_a, done_a, pass_a;
  logic [15:0] signature_a;
  logic [2:0]  state_dbg_a;

  logic        start_b, abort_b;
  logic [15:0] golden_b;
  logic [1:0]  cut_out_b;
  logic [8:0]  cut_in_b, pat_count_b;
  logic        busy_b, done_b, pass_b;
  logic [15:0] signature_b;
  logic [2:0]  state_dbg_b;
  int          fault_b;

  int total = 0;
  int bad   = 0;

  logic [8:0] pat_ref [0:510];

  cut_bist_controller #(.N_PATTERNS(NA), .SETTLE_CYCLES(SA), .LFSR_SEED(9'h001)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .golden_sig(golden_a),
    .cut_in(cut_in_a), .cut_out(cut_out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(signature_a), .pat_count(pat_count_a), .state_dbg(state_dbg_a)
  );

  cut_bist_controller #(.N_PATTERNS(NB), .SETTLE_CYCLES(SB), .LFSR_SEED(9'h000)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .golden_sig(golden_b),
    .cut_in(cut_in_b), .cut_out(cut_out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(signature_b), .pat_count(pat_count_b), .state_dbg(state_dbg_b)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference models ----------------
  // Behavioural CUT: a = v[8:5], b = v[4], c = v[3], d = v[2:0].
  // fault 1/2: f0 stuck-at-0/1, 3/4: f1 stuck-at-0/1.
  function automatic logic [1:0] cut_model(input logic [8:0] v, input int fault);
    logic [3:0] a;
    logic       b, c, f1, f0;
    logic [2:0] d;
    a  = v[8:5];
    b  = v[4];
    c  = v[3];
    d  = v[2:0];
    f1 = (a > {1'b0, d}) ^ (b & c);
    f0 = (^a) ^ (b | d[0]);
    case (fault)
      1: f0 = 1'b0;
      2: f0 = 1'b1;
      3: f1 = 1'b0;
      4: f1 = 1'b1;
      default: ;
    endcase
    return {f1, f0};
  endfunction

  always_comb cut_out_b = cut_model(cut_in_b, fault_b);

  // Signature as polynomial arithmetic: multiply by x modulo the MISR
  // polynomial (x^16 term reduced by 0x1021), then add the response.
  function automatic logic [15:0] ref_misr_add(input logic [15:0] s, input logic [1:0] r);
    int unsigned x;
    x = 32'(s) * 2;
    if (x >= 32'd65536) x = (x - 32'd65536) ^ 32'h1021;
    return 16'(x ^ 32'(r));
  endfunction

  // Pattern list for seed 1 under x^9 + x^5 + 1.
  task automatic build_patterns();
    int unsigned v;
    v = 1;
    for (int i = 0; i < 511; i++) begin
      pat_ref[i] = 9'(v);
      v = ((v * 2) % 512) + (((v / 256) + (v / 16)) % 2);
    end
  endtask

  function automatic logic [15:0] ref_sig_b(input int fault, input int npat);
    logic [15:0] s;
    s = 16'h0000;
    for (int i = 0; i < npat; i++) s = ref_misr_add(s, cut_model(pat_ref[i], fault));
    return s;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({busy_a, done_a, pass_a, signature_a, pat_count_a, cut_in_a} !== 37'd0) begin
        bad++;
        $display("FAIL reset_a cyc=%0d got busy=%b done=%b pass=%b sig=%h cnt=%0d cut_in=%h exp all zero",
                 i, busy_a, done_a, pass_a, signature_a, pat_count_a, cut_in_a);
      end
      total++;
      if ({busy_b, done_b, pass_b, signature_b, pat_count_b, cut_in_b} !== 37'd0) begin
        bad++;
        $display("FAIL reset_b cyc=%0d got busy=%b done=%b pass=%b sig=%h cnt=%0d cut_in=%h exp all zero",
                 i, busy_b, done_b, pass_b, signature_b, pat_count_b, cut_in_b);
      end
    end
  endtask

  // Called right after a negedge with dut_a idle; ends right after a negedge
  // one cycle after DONE (the first IDLE cycle).
  task automatic run_small(input logic [1:0] co, input logic [15:0] golden);
    logic [15:0] exp_sig;
    logic        exp_pass;
    int          n;
    bit          seen;
    exp_sig = 16'h0000;
    for (int i = 0; i < NA; i++) exp_sig = ref_misr_add(exp_sig, co);
    exp_pass = (exp_sig == golden);
    cut_out_a = co;
    golden_a  = golden;
    start_a   = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done_a === 1'b1) begin
        seen = 1;
      end else begin
        total++;
        if (n <= NA * PA) begin
          if (cut_in_a !== pat_ref[(n-1)/PA] || pat_count_a !== 9'((n-1)/PA)) begin
            bad++;
            $display("FAIL small_seq n=%0d got cut_in=%h cnt=%0d exp cut_in=%h cnt=%0d",
                     n, cut_in_a, pat_count_a, pat_ref[(n-1)/PA], (n-1)/PA);
          end
        end else if (cut_in_a !== pat_ref[NA-1] || pat_count_a !== 9'(NA)) begin
          bad++;
          $display("FAIL small_hold n=%0d got cut_in=%h cnt=%0d exp cut_in=%h cnt=%0d",
                   n, cut_in_a, pat_count_a, pat_ref[NA-1], NA);
        end
      end
    end
    total++;
    if (n != NA * PA + 2) begin
      bad++;
      $display("FAIL small_done_latency got=%0d exp=%0d", n, NA * PA + 2);
    end
    total++;
    if (signature_a !== exp_sig) begin
      bad++;
      $display("FAIL small_signature got=%h exp=%h", signature_a, exp_sig);
    end
    total++;
    if (pass_a !== exp_pass || busy_a !== 1'b1) begin
      bad++;
      $display("FAIL small_verdict got pass=%b busy=%b exp pass=%b busy=1", pass_a, busy_a, exp_pass);
    end
    @(negedge clk);
    total++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || pass_a !== exp_pass) begin
      bad++;
      $display("FAIL small_after_done got done=%b busy=%b pass=%b exp done=0 busy=0 pass=%b",
               done_a, busy_a, pass_a, exp_pass);
    end
  endtask

  task automatic test_small_pass();
    run_small(2'b01, 16'h0003);
    total++;
    if (signature_a !== 16'h0003 || pass_a !== 1'b1) begin
      bad++;
      $display("FAIL small_pass_fixed got sig=%h pass=%b exp sig=0003 pass=1", signature_a, pass_a);
    end
  endtask

  task automatic test_small_fail();
    run_small(2'b01, 16'h0004);
    total++;
    if (signature_a !== 16'h0003 || pass_a !== 1'b0) begin
      bad++;
      $display("FAIL small_fail_fixed got sig=%h pass=%b exp sig=0003 pass=0", signature_a, pass_a);
    end
  endtask

  // Runs launched on the first IDLE cycle after DONE, random response/golden.
  task automatic test_back_to_back();
    logic [1:0]  co;
    logic [15:0] g, s;
    for (int k = 0; k < 6; k++) begin
      co = 2'($urandom_range(0, 3));
      s = ref_misr_add(ref_misr_add(16'h0000, co), co);
      g = ($urandom_range(0, 1) == 1) ? s : (s ^ 16'($urandom_range(1, 65535)));
      run_small(co, g);
    end
  endtask

  // Full-period run on dut_b; a stray start is pulsed mid-run and must not
  // disturb the sequence.
  task automatic run_big(input int fault);
    logic [15:0] golden, exp_sig;
    logic        exp_pass;
    int          n;
    bit          seen;
    golden   = ref_sig_b(0, NB);
    exp_sig  = ref_sig_b(fault, NB);
    exp_pass = (exp_sig == golden);
    fault_b  = fault;
    golden_b = golden;
    start_b  = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < NB * PB + 20) begin
      @(negedge clk);
      n++;
      start_b = (n == 100) ? 1'b1 : 1'b0;
      if (done_b === 1'b1) begin
        seen = 1;
      end else begin
        total++;
        if (n <= NB * PB) begin
          if (cut_in_b !== pat_ref[(n-1)/PB] || pat_count_b !== 9'((n-1)/PB) || busy_b !== 1'b1) begin
            bad++;
            $display("FAIL big_seq n=%0d got cut_in=%h cnt=%0d busy=%b exp cut_in=%h cnt=%0d busy=1",
                     n, cut_in_b, pat_count_b, busy_b, pat_ref[(n-1)/PB], (n-1)/PB);
          end
        end else if (cut_in_b !== pat_ref[NB-1] || pat_count_b !== 9'(NB)) begin
          bad++;
          $display("FAIL big_hold n=%0d got cut_in=%h cnt=%0d exp cut_in=%h cnt=%0d",
                   n, cut_in_b, pat_count_b, pat_ref[NB-1], NB);
        end
      end
    end
    start_b = 1'b0;
    total++;
    if (n != NB * PB + 2) begin
      bad++;
      $display("FAIL big_done_latency fault=%0d got=%0d exp=%0d", fault, n, NB * PB + 2);
    end
    total++;
    if (signature_b !== exp_sig) begin
      bad++;
      $display("FAIL big_signature fault=%0d got=%h exp=%h", fault, signature_b, exp_sig);
    end
    total++;
    if (pass_b !== exp_pass) begin
      bad++;
      $display("FAIL big_pass fault=%0d got=%b exp=%b", fault, pass_b, exp_pass);
    end
    @(negedge clk);
    total++;
    if (done_b !== 1'b0 || busy_b !== 1'b0) begin
      bad++;
      $display("FAIL big_after_done got done=%b busy=%b exp done=0 busy=0", done_b, busy_b);
    end
  endtask

  task automatic test_golden_cut();
    run_big(0);
    total++;
    if (pass_b !== 1'b1) begin
      bad++;
      $display("FAIL golden_cut_pass got=%b exp=1", pass_b);
    end
  endtask

  task automatic test_stuck_fault();
    run_big(int'($urandom_range(1, 4)));
    fault_b = 0;
  endtask

  task automatic test_abort();
    logic [15:0] exp_sig;
    exp_sig = ref_sig_b(0, 2);
    fault_b = 0;
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    repeat (2 * PB + 1) @(negedge clk);  // first cycle of 3rd APPLY
    total++;
    if (cut_in_b !== pat_ref[2] || pat_count_b !== 9'd2) begin
      bad++;
      $display("FAIL abort_pre got cut_in=%h cnt=%0d exp cut_in=%h cnt=2", cut_in_b, pat_count_b, pat_ref[2]);
    end
    abort_b = 1'b1;
    @(posedge clk);
    #1 abort_b = 1'b0;
    @(negedge clk);
    total++;
    if (busy_b !== 1'b0 || done_b !== 1'b0 || pass_b !== 1'b0 || pat_count_b !== 9'd2 ||
        signature_b !== exp_sig || cut_in_b !== pat_ref[2]) begin
      bad++;
      $display("FAIL abort_idle got busy=%b done=%b pass=%b cnt=%0d sig=%h cut_in=%h exp 0 0 0 2 %h %h",
               busy_b, done_b, pass_b, pat_count_b, signature_b, cut_in_b, exp_sig, pat_ref[2]);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (done_b !== 1'b0 || busy_b !== 1'b0) begin
        bad++;
        $display("FAIL abort_quiet cyc=%0d got done=%b busy=%b exp 0 0", i, done_b, busy_b);
      end
    end
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    @(negedge clk);
    total++;
    if (cut_in_b !== 9'h001 || pat_count_b !== 9'd0 || busy_b !== 1'b1 || signature_b !== 16'h0000) begin
      bad++;
      $display("FAIL abort_restart got cut_in=%h cnt=%0d busy=%b sig=%h exp 001 0 1 0000",
               cut_in_b, pat_count_b, busy_b, signature_b);
    end
    abort_b = 1'b1;
    @(posedge clk);
    #1 abort_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    cut_out_a = 2'b11;
    golden_a  = 16'h0000;
    start_a   = 1'b1;
    start_b   = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (2 * PB) @(negedge clk);      // dut_b in its 2nd CAPTURE
    total++;
    if (pat_count_b !== 9'd1 || cut_in_b !== pat_ref[1]) begin
      bad++;
      $display("FAIL rst_pre got cnt=%0d cut_in=%h exp cnt=1 cut_in=%h", pat_count_b, cut_in_b, pat_ref[1]);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy_b, done_b, pass_b, signature_b, pat_count_b, cut_in_b} !== 37'd0) begin
      bad++;
      $display("FAIL rst_async_b got busy=%b done=%b pass=%b sig=%h cnt=%0d cut_in=%h exp all zero",
               busy_b, done_b, pass_b, signature_b, pat_count_b, cut_in_b);
    end
    total++;
    if ({busy_a, done_a, pass_a, signature_a, pat_count_a, cut_in_a} !== 37'd0) begin
      bad++;
      $display("FAIL rst_async_a got busy=%b done=%b pass=%b sig=%h cnt=%0d cut_in=%h exp all zero",
               busy_a, done_a, pass_a, signature_a, pat_count_a, cut_in_a);
    end
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy_b !== 1'b0 || done_b !== 1'b0 || cut_in_b !== 9'h000) begin
      bad++;
      $display("FAIL rst_stays_idle got busy=%b done=%b cut_in=%h exp 0 0 000", busy_b, done_b, cut_in_b);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst       = 1'b1;
    start_a   = 1'b0;
    abort_a   = 1'b0;
    golden_a  = 16'h0000;
    cut_out_a = 2'b00;
    start_b   = 1'b0;
    abort_b   = 1'b0;
    golden_b  = 16'h0000;
    fault_b   = 0;
    build_patterns();
    test_reset();
    test_small_pass();
    test_small_fail();
    test_back_to_back();
    test_golden_cut();
    test_stuck_fault();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
